// File: rtl/multicycle_sequencer.sv
// Multicycle MIPS-subset control sequencer: Moore control outputs per state,
// memory stalls via memReady, and a retired-instruction counter.
module multicycle_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        memReady,
  input  logic        cond,
  output logic        PCWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        memWrite,
  output logic        memToReg,
  output logic        regDst,
  output logic        regWriteEnable,
  output logic        jump,
  output logic        jumpReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic [1:0]  aluOp,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6, S_ALUWB = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_JR     = 4'd10, S_JAL  = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_retired;
  logic [5:0]  w_op, w_fn;
  logic        w_rtype_alu, w_decoded, w_retire;
  logic        w_pcw, w_irw, w_mw, w_rwe, w_ill;
  logic        w_unused;

  assign w_op     = instr[31:26];
  assign w_fn     = instr[5:0];
  assign w_unused = ^instr[25:6];

  always_comb begin
    w_rtype_alu = 1'b0;
    if (w_op == 6'b000000) begin
      case (w_fn)
        6'b100000, 6'b100100, 6'b100111,
        6'b000100, 6'b000110, 6'b000111: w_rtype_alu = 1'b1;
        default:                         w_rtype_alu = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_next    = S_FETCH;
    w_decoded = 1'b1;
    case (r_state)
      S_FETCH:  w_next = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_op == 6'b100011 || w_op == 6'b101011)      w_next = S_MEMADR;
        else if (w_op == 6'b000000 && w_fn == 6'b001000) w_next = S_JR;
        else if (w_rtype_alu)                            w_next = S_EXEC;
        else if (w_op == 6'b000100)                      w_next = S_BRANCH;
        else if (w_op == 6'b000010)                      w_next = S_JUMP;
        else if (w_op == 6'b000011)                      w_next = S_JAL;
        else begin
          w_next    = S_FETCH;
          w_decoded = 1'b0;
        end
      end
      S_MEMADR: w_next = (w_op == 6'b101011) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = memReady ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Any instruction-completing return to FETCH counts; illegal decode does not.
  always_comb begin
    case (r_state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_JR, S_JAL: w_retire = 1'b1;
      S_MEMWR:                                         w_retire = memReady;
      default:                                         w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + 32'd1;
    end
  end

  always_comb begin
    w_pcw = 1'b0; IorD = 1'b0; w_irw = 1'b0; w_mw = 1'b0; memToReg = 1'b0;
    regDst = 1'b0; w_rwe = 1'b0; jump = 1'b0; jumpReg = 1'b0; ALUSrcA = 1'b0;
    ALUSrcB = 2'b00; PCSrc = 2'b00; aluOp = 2'b00; w_ill = 1'b0;
    case (r_state)
      S_FETCH:  begin ALUSrcB = 2'b01; w_pcw = memReady; w_irw = memReady; end
      S_DECODE: begin ALUSrcB = 2'b11; w_ill = ~w_decoded; end
      S_MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      S_MEMRD:  begin IorD = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      S_MEMWB:  begin w_rwe = 1'b1; memToReg = 1'b1; end
      S_MEMWR:  begin IorD = 1'b1; w_mw = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      S_EXEC:   begin ALUSrcA = 1'b1; aluOp = 2'b10; end
      S_ALUWB:  begin ALUSrcA = 1'b1; aluOp = 2'b10; w_rwe = 1'b1; regDst = 1'b1; end
      S_BRANCH: begin ALUSrcA = 1'b1; aluOp = 2'b01; PCSrc = 2'b10; w_pcw = cond; end
      S_JUMP:   begin PCSrc = 2'b10; w_pcw = 1'b1; end
      S_JR:     begin PCSrc = 2'b10; jumpReg = 1'b1; w_pcw = 1'b1; end
      S_JAL:    begin aluOp = 2'b11; w_rwe = 1'b1; jump = 1'b1; PCSrc = 2'b10; w_pcw = 1'b1; end
      default:  ;
    endcase
  end

  // Strobes are forced low during reset since FETCH otherwise follows memReady.
  assign PCWrite        = w_pcw & ~reset;
  assign IRWrite        = w_irw & ~reset;
  assign memWrite       = w_mw  & ~reset;
  assign regWriteEnable = w_rwe & ~reset;
  assign illegal        = w_ill & ~reset;
  assign state          = r_state;
  assign retired        = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized scoreboard bench: a per-instruction path model pushes expected
// per-cycle control words; a negedge monitor pops and compares.
module tb_multicycle_sequencer;

  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        memReady = 1'b0, cond = 1'b0;
  logic        PCWrite, IorD, IRWrite, memWrite, memToReg, regDst, regWriteEnable;
  logic        jump, jumpReg, ALUSrcA, illegal;
  logic [1:0]  ALUSrcB, PCSrc, aluOp;
  logic [3:0]  state;
  logic [31:0] retired;

  multicycle_sequencer dut (
    .clock(clock), .reset(reset), .instr(instr), .memReady(memReady), .cond(cond),
    .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .memWrite(memWrite),
    .memToReg(memToReg), .regDst(regDst), .regWriteEnable(regWriteEnable),
    .jump(jump), .jumpReg(jumpReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .aluOp(aluOp), .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic pcw, iord, irw, mw, m2r, rdst, rwe, jmp, jr, asa;
    logic [1:0] asb, pcs, aop;
    logic ill;
  } ctl_t;

  typedef struct packed {
    logic [3:0]  st;
    ctl_t        c;
    logic [31:0] ret;
  } exp_t;

  ctl_t act_c;
  assign act_c = {PCWrite, IorD, IRWrite, memWrite, memToReg, regDst, regWriteEnable,
                  jump, jumpReg, ALUSrcA, ALUSrcB, PCSrc, aluOp, illegal};

  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  bit          mon_en = 1'b0;
  logic [31:0] mret = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("state",   64'(state),   64'(e.st));
      chk("ctl",     64'(act_c),   64'(e.c));
      chk("retired", 64'(retired), 64'(e.ret));
    end
  end

  task automatic step(input logic [3:0] st, input ctl_t c, input logic mr, input logic cd);
    exp_t e;
    memReady = mr;
    cond     = cd;
    e.st = st; e.c = c; e.ret = mret;
    sb.push_back(e);
    @(posedge clock); #1;
  endtask

  function automatic logic legal_op(input logic [5:0] op);
    return op == 6'd0 || op == 6'd2 || op == 6'd3 || op == 6'd4 || op == 6'd35 || op == 6'd43;
  endfunction

  function automatic logic legal_fn(input logic [5:0] fn);
    return fn == 6'd8 || fn == 6'd32 || fn == 6'd36 || fn == 6'd39 ||
           fn == 6'd4 || fn == 6'd6 || fn == 6'd7;
  endfunction

  // classes: 0 lw, 1 sw, 2 R-alu, 3 jr, 4 bleu, 5 j, 6 jal, 7 bad opcode, 8 bad funct
  function automatic logic [31:0] make_instr(input int cls);
    logic [31:0] r;
    logic [5:0]  f;
    r = $urandom;
    case (cls)
      0: return {6'b100011, r[25:0]};
      1: return {6'b101011, r[25:0]};
      2: begin
        case ($urandom_range(0, 5))
          0: f = 6'b100000; 1: f = 6'b100100; 2: f = 6'b100111;
          3: f = 6'b000100; 4: f = 6'b000110; default: f = 6'b000111;
        endcase
        return {6'b000000, r[25:6], f};
      end
      3: return {6'b000000, r[25:6], 6'b001000};
      4: return {6'b000100, r[25:0]};
      5: return {6'b000010, r[25:0]};
      6: return {6'b000011, r[25:0]};
      7: begin
        do f = 6'($urandom_range(0, 63)); while (legal_op(f));
        return {f, r[25:0]};
      end
      default: begin
        do f = 6'($urandom_range(0, 63)); while (legal_fn(f));
        return {6'b000000, r[25:6], f};
      end
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Walks one instruction through its architectural path with the given stalls.
  task automatic run_instr(input int cls, input logic [31:0] ins, input int fst,
                           input int mst, input logic cd);
    ctl_t c;
    instr = ins;
    for (int i = 0; i < fst; i++) begin
      c = '0; c.asb = 2'b01;
      step(4'd0, c, 1'b0, rb());
    end
    c = '0; c.asb = 2'b01; c.pcw = 1'b1; c.irw = 1'b1;
    step(4'd0, c, 1'b1, rb());
    c = '0; c.asb = 2'b11; c.ill = (cls >= 7);
    step(4'd1, c, rb(), rb());
    if (cls >= 7) return;
    case (cls)
      0, 1: begin
        c = '0; c.asa = 1'b1; c.asb = 2'b10;
        step(4'd2, c, rb(), rb());
        c.iord = 1'b1; c.mw = (cls == 1);
        for (int i = 0; i < mst; i++) step((cls == 1) ? 4'd5 : 4'd3, c, 1'b0, rb());
        step((cls == 1) ? 4'd5 : 4'd3, c, 1'b1, rb());
        if (cls == 0) begin
          c = '0; c.rwe = 1'b1; c.m2r = 1'b1;
          step(4'd4, c, rb(), rb());
        end
      end
      2: begin
        c = '0; c.asa = 1'b1; c.aop = 2'b10;
        step(4'd6, c, rb(), rb());
        c.rwe = 1'b1; c.rdst = 1'b1;
        step(4'd7, c, rb(), rb());
      end
      3: begin
        c = '0; c.pcs = 2'b10; c.jr = 1'b1; c.pcw = 1'b1;
        step(4'd10, c, rb(), rb());
      end
      4: begin
        c = '0; c.asa = 1'b1; c.aop = 2'b01; c.pcs = 2'b10; c.pcw = cd;
        step(4'd8, c, rb(), cd);
      end
      5: begin
        c = '0; c.pcs = 2'b10; c.pcw = 1'b1;
        step(4'd9, c, rb(), rb());
      end
      default: begin
        c = '0; c.aop = 2'b11; c.rwe = 1'b1; c.jmp = 1'b1; c.pcs = 2'b10; c.pcw = 1'b1;
        step(4'd11, c, rb(), rb());
      end
    endcase
    mret = mret + 32'd1;
  endtask

  initial begin
    int cls;
    memReady = 1'b1;
    #3;
    chk("rst_state",   64'(state),   64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_strobes", 64'({PCWrite, IRWrite, memWrite, regWriteEnable, illegal}), 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    run_instr(0, make_instr(0), 0, 0, 1'b0);
    run_instr(1, make_instr(1), 0, 3, 1'b0);
    run_instr(4, make_instr(4), 0, 0, 1'b0);
    run_instr(4, make_instr(4), 0, 0, 1'b1);
    run_instr(7, 32'hFC00_0000, 0, 0, 1'b0);
    run_instr(6, make_instr(6), 0, 0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      cls = $urandom_range(0, 8);
      run_instr(cls, make_instr(cls), $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end
    @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    mon_en = 1'b0;
    #1;

    // Abort a stalled load with an asynchronous reset between clock edges.
    instr = make_instr(0);
    memReady = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    memReady = 1'b0;
    @(posedge clock); #1;
    chk("memrd_stall", 64'(state), 64'd3);
    #2;
    reset = 1'b1;
    memReady = 1'b1;
    #1;
    chk("abort_state",   64'(state),   64'd0);
    chk("abort_retired", 64'(retired), 64'd0);
    chk("abort_strobes", 64'({PCWrite, IRWrite, memWrite, regWriteEnable, illegal}), 64'd0);
    @(posedge clock); #1;
    chk("hold_strobes", 64'({PCWrite, IRWrite, memWrite, regWriteEnable}), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_fetch_pcw", 64'(PCWrite), 64'd1);
    @(posedge clock); #1;
    chk("post_rst_decode", 64'(state), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be named clock and reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 instr  in  32  current instruction from the instruction register; opcode is [31:26], funct is [5:0].
REQ-005 memReady  in  1  combined memory has completed the current access this cycle.
REQ-006 cond  in  1  ALU branch-condition flag; 1 means rs <= rt unsigned.
REQ-007 PCWrite  out  1  PC register enable.
REQ-008 IorD  out  1  memory address select; 0 selects pcQ, 1 selects the ALU result.
REQ-009 IRWrite  out  1  instruction register enable.
REQ-010 memWrite  out  1  memory write enable.
REQ-011 memToReg  out  1  register write-data select; 0 selects the ALU result, 1 selects memory data.
REQ-012 regDst  out  1  register destination select; 1 selects instr[15:11], 0 selects instr[20:16].
REQ-013 regWriteEnable  out  1  register file write enable.
REQ-014 jump  out  1  forces the register write address to 31.
REQ-015 jumpReg  out  1  jump target select; 1 selects rs, 0 selects the pseudo-direct target.
REQ-016 ALUSrcA  out  1  ALU A operand select; 0 selects pcQ, 1 selects rs.
REQ-017 ALUSrcB  out  2  ALU B operand select: 00 rt, 01 constant 4, 10 SignImm, 11 SignImm<<2.
REQ-018 PCSrc  out  2  next-PC select: 00 ALU result, 10 jump target; 01 and 11 are never driven.
REQ-019 aluOp  out  2  ALU operation: 00 add, 01 compare, 10 decode from funct, 11 pass A.
REQ-020 state  out  4  current state encoding, for debug.
REQ-021 illegal  out  1  one-cycle pulse when an opcode or funct is not decoded.
REQ-022 retired  out  32  count of completed instructions.

Function
REQ-023 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, JR=10, JAL=11.
REQ-024 Control outputs SHALL be Moore outputs of state; any output not listed for a state SHALL be 0.
REQ-025 FETCH SHALL drive IorD=0, ALUSrcA=0, ALUSrcB=01, aluOp=00, PCSrc=00, and IRWrite=PCWrite=memReady; the block SHALL hold in FETCH while memReady=0 and go to DECODE when memReady=1.
REQ-026 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, aluOp=00, and SHALL branch on opcode.
REQ-027 From DECODE, opcode 100011 (lw) and 101011 (sw) SHALL go to MEMADR.
REQ-028 From DECODE, opcode 000000 with funct 001000 SHALL go to JR.
REQ-029 From DECODE, opcode 000000 with funct 100000, 100100, 100111, 000100, 000110, or 000111 SHALL go to EXEC.
REQ-030 From DECODE, opcode 000100 (bleu) SHALL go to BRANCH, 000010 (j) to JUMP, and 000011 (jal) to JAL.
REQ-031 Any other opcode or funct in DECODE SHALL pulse illegal for one cycle and return to FETCH; retired SHALL NOT increment.
REQ-032 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, aluOp=00, and go to MEMRD for lw or MEMWR for sw.
REQ-033 MEMRD SHALL drive IorD=1 and ALUSrcA/ALUSrcB/aluOp as in MEMADR; it SHALL hold until memReady=1, then go to MEMWB.
REQ-034 MEMWB SHALL drive regWriteEnable=1, memToReg=1, regDst=0, and go to FETCH.
REQ-035 MEMWR SHALL drive IorD=1, memWrite=1, and ALUSrcA/ALUSrcB/aluOp as in MEMADR; it SHALL hold until memReady=1, then go to FETCH.
REQ-036 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, aluOp=10, and go to ALUWB.
REQ-037 ALUWB SHALL hold EXEC's ALU selects and drive regWriteEnable=1, regDst=1, memToReg=0, then go to FETCH.
REQ-038 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, aluOp=01, and PCSrc=10 with jump target forced off; PCWrite SHALL equal cond; the branch target SHALL be held externally from DECODE. BRANCH SHALL then go to FETCH.
REQ-039 JUMP SHALL drive PCSrc=10, jumpReg=0, PCWrite=1, and go to FETCH.
REQ-040 JR SHALL drive PCSrc=10, jumpReg=1, PCWrite=1, and go to FETCH.
REQ-041 JAL SHALL drive ALUSrcA=0, aluOp=11, regWriteEnable=1, jump=1, memToReg=0, PCSrc=10, jumpReg=0, PCWrite=1, and go to FETCH; r31 receives pcQ, which is already PC+4.
REQ-042 retired SHALL increment by 1, wrapping modulo 2^32, on every transition into FETCH from MEMWB, MEMWR (on exit), ALUWB, BRANCH, JUMP, JR, or JAL.
REQ-043 Unused state codes 12-15 SHALL go to FETCH on the next clock with all outputs 0.

Reset
REQ-044 While reset=1, state SHALL be FETCH, retired=0, illegal=0, and PCWrite, IRWrite, memWrite, and regWriteEnable SHALL all be 0, independent of clock.
REQ-045 Reset asserted mid-instruction, including while stalled in MEMRD/MEMWR, SHALL abort the instruction with no write strobe after assertion and no retired increment.
REQ-046 After reset deasserts, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-047 lw with memReady=1 always -> state sequence 0,1,2,3,4,0; regWriteEnable=1 only in state 4; retired 0->1.
REQ-048 sw with memReady=0 for 3 cycles in MEMWR -> memWrite=1 for 4 cycles; retired increments once on exit.
REQ-049 bleu with cond=0, then cond=1 -> PCWrite=0 in BRANCH on the first, 1 on the second; both retire in 3 cycles.
REQ-050 opcode 111111 -> illegal pulses for 1 cycle at DECODE; state 0,1,0; retired unchanged.
REQ-051 jal -> state 0,1,11,0; in state 11, jump=1, regWriteEnable=1, PCWrite=1, PCSrc=10.
REQ-052 Reset asserted while in MEMRD with memReady=0 -> state=0 immediately, no clock needed; retired=0; all write strobes 0.
